// File: rtl/fused_triple_mult_seq_if.sv
// Operand/result handshake bundle for the sequential fused triple multiplier.
//   in_valid/in_ready/inA/inB/inC : operand triple handshake {sign,exp,man}
//   out_valid/out_ready/out       : result handshake, result held until taken
// master = operand producer / result consumer, slave = the multiplier.
interface fused_triple_mult_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic [W-1:0] inC;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;

  modport master (
    output in_valid, inA, inB, inC, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, inA, inB, inC, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/fused_triple_mult_seq.sv
// Sequential fused triple multiplier: out = A*B*C with one exponent adjust and
// one truncation at the end. Two radix-2 shift-add passes (sigA*sigB, then
// *sigC) at full width, then a single normalise/pack cycle.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : operand/result handshake (slave side of fused_triple_mult_seq_if)
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand triple
// MUL1  | SIG_W cycles: P1 = sigA*sigB, one multiplier bit per cycle, LSB first
// MUL2  | SIG_W cycles: P2 = P1*sigC, full 3*SIG_W width
// NORM  | normalise, pack, special cases into the result register
// DONE  | out_valid=1, result held until out_ready
module fused_triple_mult_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  fused_triple_mult_seq_if.slave  bus
);
  localparam int SIG_W = MAN_W + 1;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int PW    = 3 * SIG_W;
  localparam int EW    = EXP_W + 3;
  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int CW    = $clog2(SIG_W) + 1;

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, NORM, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [PW-1:0]         mcand_q, mcand_d;
  logic [SIG_W-1:0]      mplier_q, mplier_d;
  logic [SIG_W-1:0]      sig_c_q, sig_c_d;
  logic                  sign_q, sign_d;
  logic                  nan_q, nan_d;
  logic                  inf_q, inf_d;
  logic                  zero_q, zero_d;
  logic signed [EW-1:0]  e_sum_q, e_sum_d;
  logic [W-1:0]          out_q, out_d;

  function automatic logic f_zero(input logic [W-1:0] x);
    return x[W-2 -: EXP_W] == '0;
  endfunction

  function automatic logic f_inf(input logic [W-1:0] x);
    return (x[W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] == '0);
  endfunction

  function automatic logic f_nan(input logic [W-1:0] x);
    return (x[W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] != '0);
  endfunction

  // Denormals are flushed: a zero exponent yields a zero significand.
  function automatic logic [SIG_W-1:0] f_sig(input logic [W-1:0] x);
    return f_zero(x) ? '0 : {1'b1, x[MAN_W-1:0]};
  endfunction

  function automatic logic signed [EW-1:0] f_exp(input logic [W-1:0] x);
    return $signed({3'b000, x[W-2 -: EXP_W]});
  endfunction

  logic [PW-1:0]        acc_add;
  logic [1:0]           k;
  logic [MAN_W-1:0]     man_fin;
  logic signed [EW-1:0] e_fin;

  always_comb begin
    acc_add = mplier_q[0] ? acc_q + mcand_q : acc_q;

    // P2 lies in [1,8) * 2**(3*MAN_W); k places the leading one at bit 3*MAN_W.
    if (acc_q[PW-1]) begin
      k       = 2'd2;
      man_fin = acc_q[PW-2 -: MAN_W];
    end else if (acc_q[PW-2]) begin
      k       = 2'd1;
      man_fin = acc_q[PW-3 -: MAN_W];
    end else begin
      k       = 2'd0;
      man_fin = acc_q[PW-4 -: MAN_W];
    end
    e_fin = e_sum_q + $signed({{(EW-2){1'b0}}, k});

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sig_c_d  = sig_c_q;
    sign_d   = sign_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    e_sum_d  = e_sum_q;
    out_d    = out_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d    = '0;
          mcand_d  = PW'(f_sig(bus.inA));
          mplier_d = f_sig(bus.inB);
          sig_c_d  = f_sig(bus.inC);
          cnt_d    = CW'(SIG_W - 1);
          sign_d   = bus.inA[W-1] ^ bus.inB[W-1] ^ bus.inC[W-1];
          nan_d    = f_nan(bus.inA) | f_nan(bus.inB) | f_nan(bus.inC);
          inf_d    = f_inf(bus.inA) | f_inf(bus.inB) | f_inf(bus.inC);
          zero_d   = f_zero(bus.inA) | f_zero(bus.inB) | f_zero(bus.inC);
          e_sum_d  = f_exp(bus.inA) + f_exp(bus.inB) + f_exp(bus.inC)
                     - $signed(EW'(2 * BIAS));
          state_d  = MUL1;
        end
      end
      MUL1, MUL2: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (state_q == MUL1) begin
            // P1 becomes the multiplicand of the second pass.
            mcand_d  = acc_add;
            acc_d    = '0;
            mplier_d = sig_c_q;
            cnt_d    = CW'(SIG_W - 1);
            state_d  = MUL2;
          end else begin
            state_d  = NORM;
          end
        end
      end
      NORM: begin
        if (nan_q || (inf_q && zero_q))
          out_d = {sign_q, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (inf_q)
          out_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (zero_q)
          out_d = {sign_q, {(W-1){1'b0}}};
        else if (e_fin >= $signed(EW'(2**EXP_W - 1)))
          out_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e_fin <= $signed(EW'(0)))
          out_d = {sign_q, {(W-1){1'b0}}};
        else
          out_d = {sign_q, e_fin[EXP_W-1:0], man_fin};
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sig_c_q  <= '0;
      sign_q   <= 1'b0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      e_sum_q  <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sig_c_q  <= sig_c_d;
      sign_q   <= sign_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      e_sum_q  <= e_sum_d;
      out_q    <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;

endmodule
